// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock-enable divider: emits a divided waveform plus a
// period-start tick, and changes ratio or stops only on period boundaries.
module clk_div_ctrl #(
  parameter int CNT_W   = 8,
  parameter int DIV_RST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_clk,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] cur_div
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pending_q, pending_d;
  logic             div_clk_q, div_clk_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic             wrap;
  logic             apply;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W:0]   half;

  assign wrap    = (cnt_q == cur_div_q - CNT_W'(1));
  assign cnt_inc = cnt_q + CNT_W'(1);
  // Extra bit keeps (N+1)>>1 correct at the top of the ratio range.
  assign half    = ({1'b0, cur_div_q} + (CNT_W+1)'(1)) >> 1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    pending_d  = pending_q;
    div_clk_d  = div_clk_q;
    tick_d     = 1'b0;
    err_d      = 1'b0;
    apply      = 1'b0;

    if (cfg_valid && !pending_q) begin
      if (cfg_div < CNT_W'(2)) begin
        err_d = 1'b1;
      end else begin
        pend_div_d = cfg_div;
        pending_d  = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        div_clk_d = 1'b0;
        apply     = pending_q;
        if (en) begin
          state_d   = RUN;
          tick_d    = 1'b1;
          div_clk_d = 1'b1;
        end
      end
      RUN, STOPPING: begin
        if (state_q == RUN && !en)      state_d = STOPPING;
        if (state_q == STOPPING && en)  state_d = RUN;
        if (wrap) begin
          cnt_d = '0;
          apply = pending_q;
          if (state_q == STOPPING && !en) begin
            state_d   = IDLE;
            div_clk_d = 1'b0;
          end else begin
            tick_d    = 1'b1;
            div_clk_d = 1'b1;
          end
        end else begin
          cnt_d     = cnt_inc;
          div_clk_d = ({1'b0, cnt_inc} < half);
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept and apply never coincide: acceptance requires nothing pending.
    if (apply) begin
      cur_div_d = pend_div_q;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_div_q  <= CNT_W'(DIV_RST);
      pend_div_q <= '0;
      pending_q  <= 1'b0;
      div_clk_q  <= 1'b0;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      pending_q  <= pending_d;
      div_clk_q  <= div_clk_d;
      tick_q     <= tick_d;
      err_q      <= err_d;
    end
  end

  assign cfg_ready = !pending_q;
  assign cfg_err   = err_q;
  assign div_clk   = div_clk_q;
  assign tick      = tick_q;
  assign busy      = (state_q != IDLE);
  assign cur_div   = cur_div_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: a vector table for start/config/error
// behaviour, then sequences for stop, restart, reset and ratio extremes.
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready, cfg_err, div_clk, tick, busy;
  logic [7:0] cur_div;

  int n_vec = 0;
  int n_bad = 0;

  clk_div_ctrl #(.CNT_W(8), .DIV_RST(4)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .div_clk(div_clk), .tick(tick),
    .busy(busy), .cur_div(cur_div)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, e, v;
    logic [7:0] d;
    logic       t, c, b, y, er;
    logic [7:0] cu;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, e, v, input logic [7:0] d,
                              input logic t, c, b, y, er, input logic [7:0] cu);
    vec_t x;
    x.r = r; x.e = e; x.v = v; x.d = d;
    x.t = t; x.c = c; x.b = b; x.y = y; x.er = er; x.cu = cu;
    return x;
  endfunction

  task automatic step(input logic r, e, v, input logic [7:0] d);
    rst = r; en = e; cfg_valid = v; cfg_div = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Start from reset, load ratio n while idle, then run for the given periods.
  task automatic run_n(input int n, input int periods);
    int c, hi;
    step(1, 0, 0, 0);
    step(0, 0, 1, 8'(n));
    chk("run_pend_rdy", 32'(cfg_ready), 0);
    step(0, 1, 0, 0);
    chk("run_first_tick", 32'(tick), 1);
    chk("run_first_dclk", 32'(div_clk), 1);
    chk("run_cur_div", 32'(cur_div), 32'(n));
    chk("run_busy", 32'(busy), 1);
    hi = 1;
    for (int k = 0; k < n * periods - 1; k++) begin
      step(0, 1, 0, 0);
      c = (k + 1) % n;
      chk($sformatf("run%0d_dclk_c%0d", n, c), 32'(div_clk), 32'(c < (n + 1) / 2));
      chk($sformatf("run%0d_tick_c%0d", n, c), 32'(tick), 32'(c == 0));
      if (k < n - 1) hi += int'(div_clk);
    end
    chk($sformatf("run%0d_high_cycles", n), 32'(hi), 32'((n + 1) / 2));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;

    //           r  e  v  div   tick dclk busy rdy err cur
    vq.push_back(mk(1, 0, 0, 0,  0, 0, 0, 1, 0, 4));
    vq.push_back(mk(0, 0, 0, 0,  0, 0, 0, 1, 0, 4));
    vq.push_back(mk(0, 1, 0, 0,  1, 1, 1, 1, 0, 4)); // cnt0
    vq.push_back(mk(0, 1, 0, 0,  0, 1, 1, 1, 0, 4)); // cnt1
    vq.push_back(mk(0, 1, 0, 0,  0, 0, 1, 1, 0, 4)); // cnt2
    vq.push_back(mk(0, 1, 0, 0,  0, 0, 1, 1, 0, 4)); // cnt3
    vq.push_back(mk(0, 1, 0, 0,  1, 1, 1, 1, 0, 4)); // cnt0
    vq.push_back(mk(0, 1, 0, 0,  0, 1, 1, 1, 0, 4)); // cnt1
    vq.push_back(mk(0, 1, 1, 6,  0, 0, 1, 0, 0, 4)); // accept 6, cnt2
    vq.push_back(mk(0, 1, 1, 6,  0, 0, 1, 0, 0, 4)); // not ready, cnt3
    vq.push_back(mk(0, 1, 0, 0,  1, 1, 1, 1, 0, 6)); // apply at wrap
    vq.push_back(mk(0, 1, 1, 0,  0, 1, 1, 1, 1, 6)); // reject 0, cnt1
    vq.push_back(mk(0, 1, 1, 1,  0, 1, 1, 1, 1, 6)); // reject 1, cnt2
    vq.push_back(mk(0, 1, 0, 0,  0, 0, 1, 1, 0, 6)); // cnt3
    vq.push_back(mk(0, 1, 0, 0,  0, 0, 1, 1, 0, 6)); // cnt4
    vq.push_back(mk(0, 1, 0, 0,  0, 0, 1, 1, 0, 6)); // cnt5
    vq.push_back(mk(0, 1, 1, 4,  1, 1, 1, 0, 0, 6)); // accept on wrap edge
    vq.push_back(mk(0, 1, 0, 0,  0, 1, 1, 0, 0, 6)); // cnt1
    vq.push_back(mk(0, 1, 0, 0,  0, 1, 1, 0, 0, 6)); // cnt2
    vq.push_back(mk(0, 1, 0, 0,  0, 0, 1, 0, 0, 6)); // cnt3
    vq.push_back(mk(0, 1, 0, 0,  0, 0, 1, 0, 0, 6)); // cnt4
    vq.push_back(mk(0, 1, 0, 0,  0, 0, 1, 0, 0, 6)); // cnt5
    vq.push_back(mk(0, 1, 0, 0,  1, 1, 1, 1, 0, 4)); // applied next wrap
    vq.push_back(mk(0, 1, 0, 0,  0, 1, 1, 1, 0, 4)); // cnt1
    vq.push_back(mk(0, 1, 0, 0,  0, 0, 1, 1, 0, 4)); // cnt2

    @(posedge clk); #1;
    foreach (vq[i]) begin
      step(vq[i].r, vq[i].e, vq[i].v, vq[i].d);
      n_vec++;
      if ({tick, div_clk, busy, cfg_ready, cfg_err, cur_div} !==
          {vq[i].t, vq[i].c, vq[i].b, vq[i].y, vq[i].er, vq[i].cu}) begin
        n_bad++;
        $display("FAIL vec%0d: got t/c/b/y/e=%b%b%b%b%b cur=%0d expected %b%b%b%b%b cur=%0d",
                 i, tick, div_clk, busy, cfg_ready, cfg_err, cur_div,
                 vq[i].t, vq[i].c, vq[i].b, vq[i].y, vq[i].er, vq[i].cu);
      end
    end

    // N=5 loaded while idle, then stop requested at cnt=1.
    step(1, 0, 0, 0);
    step(0, 0, 1, 5);
    chk("idle_pend_rdy", 32'(cfg_ready), 0);
    chk("idle_pend_cur", 32'(cur_div), 4);
    step(0, 0, 0, 0);
    chk("idle_apply_cur", 32'(cur_div), 5);
    chk("idle_apply_rdy", 32'(cfg_ready), 1);
    chk("idle_apply_busy", 32'(busy), 0);
    step(0, 1, 0, 0); chk("s5_tick0", 32'(tick), 1);
    step(0, 1, 0, 0); chk("s5_dclk1", 32'(div_clk), 1);
    step(0, 0, 0, 0); chk("stop_c2_busy", 32'(busy), 1); chk("stop_c2_dclk", 32'(div_clk), 1);
    step(0, 0, 0, 0); chk("stop_c3_dclk", 32'(div_clk), 0); chk("stop_c3_busy", 32'(busy), 1);
    step(0, 0, 0, 0); chk("stop_c4_busy", 32'(busy), 1); chk("stop_c4_tick", 32'(tick), 0);
    step(0, 0, 0, 0);
    chk("stop_idle_busy", 32'(busy), 0);
    chk("stop_idle_dclk", 32'(div_clk), 0);
    chk("stop_idle_tick", 32'(tick), 0);
    step(0, 0, 0, 0); chk("stop_no_tick", 32'(tick), 0);

    // Stop request withdrawn at cnt=3: no gap in the tick train.
    step(0, 1, 0, 0); chk("re_tick0", 32'(tick), 1);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0); chk("re_c2_busy", 32'(busy), 1);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0); chk("re_c4_dclk", 32'(div_clk), 0); chk("re_c4_busy", 32'(busy), 1);
    step(0, 1, 0, 0); chk("re_wrap_tick", 32'(tick), 1);
    for (int k = 0; k < 10; k++) begin
      step(0, 1, 0, 0);
      chk($sformatf("re_tick_k%0d", k), 32'(tick), 32'(k % 5 == 4));
      chk($sformatf("re_dclk_k%0d", k), 32'(div_clk), 32'((k + 1) % 5 < 3));
    end

    // Reset mid-period with a ratio pending.
    step(0, 1, 0, 0);
    step(0, 1, 1, 9);
    chk("rp_pend_rdy", 32'(cfg_ready), 0);
    step(1, 1, 0, 0);
    chk("rp_busy", 32'(busy), 0);
    chk("rp_dclk", 32'(div_clk), 0);
    chk("rp_tick", 32'(tick), 0);
    chk("rp_err", 32'(cfg_err), 0);
    chk("rp_rdy", 32'(cfg_ready), 1);
    chk("rp_cur", 32'(cur_div), 4);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rp_not_applied", 32'(cur_div), 4);

    run_n(3, 3);
    run_n(2, 3);
    run_n(255, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
